// File: rtl/sevenseg_prio_scan.sv
// Multiplexed 7-segment scanner: each digit shows the highest
// pending request index as a hex glyph, with blanking and blink.
module sevenseg_prio_scan #(
  parameter int N_REQ        = 4,
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 8,
  parameter int BLINK_ROUNDS = 64,
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [N_DIGITS*N_REQ-1:0] req,
  input  logic [N_DIGITS-1:0]       blink,
  output logic [6:0]                segments,
  output logic [N_DIGITS-1:0]       an,
  output logic [DW-1:0]             digit_idx
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int RW = (BLINK_ROUNDS > 1) ? $clog2(BLINK_ROUNDS) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
  localparam logic [DW-1:0] DIG_LAST   = DW'(N_DIGITS - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(BLINK_ROUNDS - 1);

  logic [N_DIGITS*N_REQ-1:0] req_q;
  logic [SW-1:0]             slot_cnt;
  logic [RW-1:0]             round_cnt;
  logic                      blink_phase;

  logic [N_REQ-1:0]    cur_req;
  logic                cur_blink;
  logic [N_DIGITS-1:0] sel_n;
  logic                hit;
  logic [3:0]          hi_idx;
  logic [6:0]          seg_d;
  logic [N_DIGITS-1:0] an_d;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'b000_0001;
      4'h1: g = 7'b100_1111;
      4'h2: g = 7'b001_0010;
      4'h3: g = 7'b000_0110;
      4'h4: g = 7'b100_1100;
      4'h5: g = 7'b010_0100;
      4'h6: g = 7'b010_0000;
      4'h7: g = 7'b000_1111;
      4'h8: g = 7'b000_0000;
      4'h9: g = 7'b000_0100;
      4'hA: g = 7'b000_1000;
      4'hB: g = 7'b110_0000;
      4'hC: g = 7'b011_0001;
      4'hD: g = 7'b100_0010;
      4'hE: g = 7'b011_0000;
      default: g = 7'b011_1000;
    endcase
    return g;
  endfunction

  // Input capture, free-running regardless of scan enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0;
    end else begin
      req_q <= req;
    end
  end

  // Slot, digit and round counters; all freeze while en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      round_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (en) begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        if (digit_idx == DIG_LAST) begin
          digit_idx <= '0;
          if (round_cnt == ROUND_LAST) begin
            round_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            round_cnt <= round_cnt + 1'b1;
          end
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // Select the request slice, blink bit and anode for the current digit.
  always_comb begin
    cur_req   = '0;
    cur_blink = 1'b0;
    sel_n     = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (digit_idx == DW'(k)) begin
        cur_req   = req_q[k*N_REQ +: N_REQ];
        cur_blink = blink[k];
        sel_n[k]  = 1'b0;
      end
    end
  end

  // Priority encode: ascending scan so the highest set bit wins.
  always_comb begin
    hit    = 1'b0;
    hi_idx = '0;
    for (int b = 0; b < N_REQ; b++) begin
      if (cur_req[b]) begin
        hit    = 1'b1;
        hi_idx = 4'(b);
      end
    end
  end

  // Next output values: glyph or blank, anode gated by blanking/blink.
  always_comb begin
    seg_d = hit ? glyph(hi_idx) : 7'b111_1111;
    an_d  = '1;
    if (en && (slot_cnt >= BLANK_END) &&
        !(cur_blink && blink_phase)) begin
      an_d = sel_n;
    end
  end

  // Registered outputs for glitch-free segment and anode drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segments <= 7'b111_1111;
      an       <= '1;
    end else begin
      segments <= seg_d;
      an       <= an_d;
    end
  end

endmodule
